// File: rtl/ecpu_pkg.sv
// Shared types and constants for the EC point unit: FSM states, op/command encodings, secp256k1 defaults.
package ecpu_pkg;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_DBL  = 1'b1;
  localparam logic CMD_MUL = 1'b0;
  localparam logic CMD_INV = 1'b1;

  localparam logic [255:0] SECP_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP_A = 256'd0;
  localparam logic [255:0] SECP_B = 256'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_CLASSIFY, S_ADD_NUM, S_ADD_DEN, S_DBL_NUM, S_DBL_ACC, S_DBL_DEN, S_INV,
    S_LAM, S_SQ, S_RX1, S_RX2, S_RY1, S_RY2, S_RY3, S_OUT
  } ecpu_state_t;

  typedef enum logic [1:0] {MS_IDLE, MS_MUL, MS_INV} ms_state_t;

endpackage

// File: rtl/ec_point_unit_if.sv
// Request/response bundle of the EC point unit; ECPU_CYCLE_CNT_EN adds the cycles field.
interface ec_point_unit_if #(parameter int WIDTH = 256);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] px, py, qx, qy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rx, ry;
  logic             r_inf;
`ifdef ECPU_CYCLE_CNT_EN
  logic [31:0]      cycles;
`endif

  modport master (
    output in_valid, op, px, py, qx, qy, out_ready,
`ifdef ECPU_CYCLE_CNT_EN
    input cycles,
`endif
    input in_ready, out_valid, rx, ry, r_inf
  );

  modport slave (
    input in_valid, op, px, py, qx, qy, out_ready,
`ifdef ECPU_CYCLE_CNT_EN
    output cycles,
`endif
    output in_ready, out_valid, rx, ry, r_inf
  );
endinterface

// File: rtl/ecpu_mod_seq.sv
// Serial GF(P) multiplier (WIDTH cycles) and binary inverter (<= ~4*WIDTH cycles) behind one start/done pulse pair.
// i_start is only honoured when idle; o_done pulses one cycle with o_res.
module ecpu_mod_seq import ecpu_pkg::*; #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = SECP_P[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_cmd,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);
  localparam int CW = $clog2(WIDTH) + 1;

  ms_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2;
  logic [WIDTH-1:0] w_dbl, w_mul_acc;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (a - b + P);
  endfunction

  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
    return t[WIDTH:1];
  endfunction

  // MSB-first double-and-add: r_u shifts the multiplier, r_v holds the multiplicand, r_x1 accumulates
  always_comb begin
    w_dbl     = add_mod(r_x1, r_x1);
    w_mul_acc = r_u[WIDTH-1] ? add_mod(w_dbl, r_v) : w_dbl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MS_IDLE;
      r_cnt   <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      o_done  <= 1'b0;
      o_res   <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        MS_IDLE: if (i_start) begin
          r_cnt <= '0;
          if (i_cmd == CMD_INV) begin
            r_u     <= i_a;
            r_v     <= P;
            r_x1    <= WIDTH'(1);
            r_x2    <= '0;
            r_state <= MS_INV;
          end else begin
            r_u     <= i_b;
            r_v     <= i_a;
            r_x1    <= '0;
            r_state <= MS_MUL;
          end
        end
        MS_MUL: begin
          r_x1  <= w_mul_acc;
          r_u   <= r_u << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            o_done  <= 1'b1;
            o_res   <= w_mul_acc;
            r_state <= MS_IDLE;
          end
        end
        // Invariants: x1*a == u and x2*a == v (mod P); stop when either side reaches 1
        MS_INV: begin
          if (r_u == WIDTH'(1) || r_v == WIDTH'(1) || r_u == '0) begin
            o_done  <= 1'b1;
            o_res   <= (r_u == WIDTH'(1)) ? r_x1 : (r_v == WIDTH'(1)) ? r_x2 : '0;
            r_state <= MS_IDLE;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= half_mod(r_x1);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= half_mod(r_x2);
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= sub_mod(r_x1, r_x2);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= sub_mod(r_x2, r_x1);
          end
        end
        default: r_state <= MS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ec_point_unit.sv
// Affine short-Weierstrass point add/double over GF(P); data-dependent latency dominated by WIDTH-cycle multiplies and one inversion.
// in_ready is low from accept until the result handshake; out_valid holds R until out_ready. ECPU_CYCLE_CNT_EN adds a busy-cycle counter.
module ec_point_unit import ecpu_pkg::*; #(
  parameter int               WIDTH = 256,
  parameter logic [WIDTH-1:0] P     = SECP_P[WIDTH-1:0],
  parameter logic [WIDTH-1:0] A     = SECP_A[WIDTH-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  ec_point_unit_if.slave  bus
);
  ecpu_state_t      r_state;
  logic             r_op, r_inf, r_out_valid, r_in_ready, r_issued;
  logic [WIDTH-1:0] r_px, r_py, r_qx, r_qy, r_num, r_den, r_lam, r_t, r_rx, r_ry;

  logic             w_accept, w_p_inf, w_q_inf, w_same_x, w_is_prim, w_ms_start, w_ms_cmd, w_ms_done;
  logic [WIDTH:0]   w_ysum;
  logic [WIDTH-1:0] w_ms_a, w_ms_b, w_ms_res, w_num3;

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (a - b + P);
  endfunction

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_p_inf  = (r_px == '0) && (r_py == '0);
  assign w_q_inf  = (r_qx == '0) && (r_qy == '0);
  assign w_same_x = (r_px == r_qx);
  assign w_ysum   = {1'b0, r_py} + {1'b0, r_qy};
  assign w_num3   = add_mod(add_mod(add_mod(r_t, r_t), r_t), A);

  always_comb begin
    w_is_prim = 1'b1;
    w_ms_cmd  = CMD_MUL;
    w_ms_a    = r_px;
    w_ms_b    = r_px;
    case (r_state)
      S_DBL_NUM: ;
      S_INV:     begin w_ms_cmd = CMD_INV; w_ms_a = r_den; w_ms_b = '0; end
      S_LAM:     begin w_ms_a = r_num; w_ms_b = r_den; end
      S_SQ:      begin w_ms_a = r_lam; w_ms_b = r_lam; end
      S_RY2:     begin w_ms_a = r_lam; w_ms_b = r_t; end
      default:   w_is_prim = 1'b0;
    endcase
  end

  assign w_ms_start = w_is_prim && !r_issued;

  ecpu_mod_seq #(.WIDTH(WIDTH), .P(P)) u_mod_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_ms_start),
    .i_cmd   (w_ms_cmd),
    .i_a     (w_ms_a),
    .i_b     (w_ms_b),
    .o_done  (w_ms_done),
    .o_res   (w_ms_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_inf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_issued    <= 1'b0;
      r_px <= '0; r_py <= '0; r_qx <= '0; r_qy <= '0;
      r_num <= '0; r_den <= '0; r_lam <= '0; r_t <= '0; r_rx <= '0; r_ry <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op       <= bus.op;
          r_px       <= bus.px;
          r_py       <= bus.py;
          r_qx       <= bus.qx;
          r_qy       <= bus.qy;
          r_in_ready <= 1'b0;
          r_state    <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          if (r_op == OP_DBL && (w_p_inf || r_py == '0)) begin
            r_rx <= '0; r_ry <= '0; r_inf <= 1'b1; r_out_valid <= 1'b1; r_state <= S_OUT;
          end else if (r_op == OP_ADD && w_p_inf) begin
            r_rx <= r_qx; r_ry <= r_qy; r_inf <= w_q_inf; r_out_valid <= 1'b1; r_state <= S_OUT;
          end else if (r_op == OP_ADD && w_q_inf) begin
            r_rx <= r_px; r_ry <= r_py; r_inf <= 1'b0; r_out_valid <= 1'b1; r_state <= S_OUT;
          end else if (r_op == OP_ADD && w_same_x && (w_ysum == {1'b0, P} || w_ysum == '0)) begin
            r_rx <= '0; r_ry <= '0; r_inf <= 1'b1; r_out_valid <= 1'b1; r_state <= S_OUT;
          end else if (r_op == OP_ADD && !w_same_x) begin
            r_state <= S_ADD_NUM;
          end else begin
            // Doubling reuses the add tail with x2 = px
            r_qx    <= r_px;
            r_state <= S_DBL_NUM;
          end
        end
        S_ADD_NUM: begin r_num <= sub_mod(r_qy, r_py); r_state <= S_ADD_DEN; end
        S_ADD_DEN: begin r_den <= sub_mod(r_qx, r_px); r_state <= S_INV; end
        S_DBL_ACC: begin r_num <= w_num3; r_state <= S_DBL_DEN; end
        S_DBL_DEN: begin r_den <= add_mod(r_py, r_py); r_state <= S_INV; end
        S_RX1:     begin r_t <= sub_mod(r_t, r_px); r_state <= S_RX2; end
        S_RX2:     begin r_rx <= sub_mod(r_t, r_qx); r_state <= S_RY1; end
        S_RY1:     begin r_t <= sub_mod(r_px, r_rx); r_state <= S_RY2; end
        S_RY3: begin
          r_ry        <= sub_mod(r_t, r_py);
          r_inf       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: if (bus.out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: if (w_is_prim) begin
          if (!r_issued) begin
            r_issued <= 1'b1;
          end else if (w_ms_done) begin
            r_issued <= 1'b0;
            case (r_state)
              S_DBL_NUM: begin r_t   <= w_ms_res; r_state <= S_DBL_ACC; end
              S_INV:     begin r_den <= w_ms_res; r_state <= S_LAM; end
              S_LAM:     begin r_lam <= w_ms_res; r_state <= S_SQ; end
              S_SQ:      begin r_t   <= w_ms_res; r_state <= S_RX1; end
              default:   begin r_t   <= w_ms_res; r_state <= S_RY3; end
            endcase
          end
        end
      endcase
    end
  end

`ifdef ECPU_CYCLE_CNT_EN
  logic [31:0] r_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) r_cycles <= '0;
    end else if (r_state != S_OUT && r_cycles != '1) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end
  assign bus.cycles = r_cycles;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.rx        = r_rx;
  assign bus.ry        = r_ry;
  assign bus.r_inf     = r_inf;
endmodule

// File: tb/tb_ec_point_unit.sv
// Bench for ec_point_unit: toy curve y^2=x^3+2x+3 over GF(97) against an integer group-law model, plus secp256k1 2G.
module tb_ec_point_unit;
  import ecpu_pkg::*;

  localparam int TP = 97;
  localparam int TA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ec_point_unit_if #(.WIDTH(8))   t_if();
  ec_point_unit_if #(.WIDTH(256)) s_if();

  ec_point_unit #(.WIDTH(8), .P(8'd97), .A(8'd2)) u_toy (.clk(clk), .rst_n(rst_n), .bus(t_if));
  ec_point_unit u_secp (.clk(clk), .rst_n(rst_n), .bus(s_if));

  int n_checks = 0;
  int n_pass   = 0;
  int pt_x[$];
  int pt_y[$];

  function automatic int md(input longint v);
    longint r;
    r = v % TP;
    if (r < 0) r = r + TP;
    return int'(r);
  endfunction

  function automatic int minv(input int a);
    for (int i = 1; i < TP; i++) if (md(longint'(a) * i) == 1) return i;
    return 0;
  endfunction

  // Textbook affine group law with (0,0) as the identity
  function automatic void ref_pt(input int op, input int px, input int py, input int qx, input int qy,
                                 output int rx, output int ry, output bit inf);
    int lam, x2;
    bit pinf, qinf;
    rx = 0; ry = 0; inf = 1'b0;
    pinf = (px == 0 && py == 0);
    qinf = (qx == 0 && qy == 0);
    if (op == 1) begin
      if (pinf || py == 0) begin inf = 1'b1; return; end
      lam = md(longint'(md(3 * px * px + TA)) * minv(md(2 * py)));
      x2 = px;
    end else if (pinf) begin
      rx = qx; ry = qy; inf = qinf; return;
    end else if (qinf) begin
      rx = px; ry = py; return;
    end else if (px == qx) begin
      if (md(py + qy) == 0) begin inf = 1'b1; return; end
      lam = md(longint'(md(3 * px * px + TA)) * minv(md(2 * py)));
      x2 = px;
    end else begin
      lam = md(longint'(md(qy - py)) * minv(md(qx - px)));
      x2 = qx;
    end
    rx = md(lam * lam - px - x2);
    ry = md(longint'(lam) * (px - rx) - py);
  endfunction

  task automatic toy_txn(input bit op, input int px, input int py, input int qx, input int qy, input int hold,
                         output int rx, output int ry, output bit inf, output int cyc, output bit ok);
    ok = 1'b1; cyc = 0; rx = 0; ry = 0; inf = 1'b0;
    for (int i = 0; i < 50 && !t_if.in_ready; i++) begin @(posedge clk); #1; end
    if (!t_if.in_ready) begin ok = 1'b0; return; end
    t_if.op = op; t_if.px = 8'(px); t_if.py = 8'(py); t_if.qx = 8'(qx); t_if.qy = 8'(qy);
    t_if.in_valid = 1'b1;
    @(posedge clk); #1;
    t_if.in_valid = 1'b0;
    while (!t_if.out_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    if (!t_if.out_valid) begin ok = 1'b0; return; end
    rx = int'(t_if.rx); ry = int'(t_if.ry); inf = t_if.r_inf;
    repeat (hold) begin @(posedge clk); #1; end
    t_if.out_ready = 1'b1;
    @(posedge clk); #1;
    t_if.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (t_if.in_ready !== 1'b1 || t_if.out_valid !== 1'b0) $display("FAIL reset_toy_hs: in_ready=%0b out_valid=%0b want 1/0", t_if.in_ready, t_if.out_valid);
    else n_pass++;
    n_checks++;
    if (t_if.rx !== 8'd0 || t_if.ry !== 8'd0 || t_if.r_inf !== 1'b0) $display("FAIL reset_toy_r: rx=%0d ry=%0d inf=%0b want 0/0/0", t_if.rx, t_if.ry, t_if.r_inf);
    else n_pass++;
    n_checks++;
    if (s_if.in_ready !== 1'b1 || s_if.out_valid !== 1'b0) $display("FAIL reset_secp_hs: in_ready=%0b out_valid=%0b want 1/0", s_if.in_ready, s_if.out_valid);
    else n_pass++;
    n_checks++;
    if (s_if.rx !== 256'd0 || s_if.ry !== 256'd0 || s_if.r_inf !== 1'b0) $display("FAIL reset_secp_r: rx=%0h inf=%0b want 0/0", s_if.rx, s_if.r_inf);
    else n_pass++;
`ifdef ECPU_CYCLE_CNT_EN
    n_checks++;
    if (t_if.cycles !== 32'd0) $display("FAIL reset_cycles: got %0d want 0", t_if.cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_vectors;
    int vec [6][8];
    int rx, ry, cyc;
    bit inf, ok;
    vec = '{'{1, 3, 6, 0, 0, 80, 10, 0}, '{0, 3, 6, 80, 10, 80, 87, 0}, '{0, 3, 6, 3, 91, 0, 0, 1},
            '{1, 5, 0, 0, 0, 0, 0, 1},   '{0, 3, 6, 3, 6, 80, 10, 0},   '{0, 0, 0, 3, 6, 3, 6, 0}};
    for (int v = 0; v < 6; v++) begin
      toy_txn(vec[v][0] != 0, vec[v][1], vec[v][2], vec[v][3], vec[v][4], 0, rx, ry, inf, cyc, ok);
      n_checks++;
      if (!ok) $display("FAIL vec%0d_timeout: no result within budget, want result", v);
      else n_pass++;
      n_checks++;
      if (rx !== vec[v][5] || ry !== vec[v][6] || int'(inf) !== vec[v][7])
        $display("FAIL vec%0d_result: got (%0d,%0d,inf=%0b) want (%0d,%0d,inf=%0d)", v, rx, ry, inf, vec[v][5], vec[v][6], vec[v][7]);
      else n_pass++;
    end
  endtask

  task automatic test_hold;
    int cyc = 0;
    t_if.op = 1'b0; t_if.px = 8'd0; t_if.py = 8'd0; t_if.qx = 8'd3; t_if.qy = 8'd6;
    t_if.in_valid = 1'b1;
    @(posedge clk); #1;
    t_if.in_valid = 1'b0;
    while (!t_if.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
`ifdef ECPU_CYCLE_CNT_EN
    n_checks++;
    if (t_if.cycles !== 32'(cyc)) $display("FAIL hold_cycles: got %0d want %0d", t_if.cycles, cyc);
    else n_pass++;
`endif
    for (int i = 0; i < 10; i++) begin
      t_if.in_valid = i[0];
      t_if.px = 8'(20 + i); t_if.qx = 8'(40 + i);
      n_checks++;
      if (t_if.out_valid !== 1'b1 || t_if.rx !== 8'd3 || t_if.ry !== 8'd6 || t_if.in_ready !== 1'b0)
        $display("FAIL hold_stable%0d: ov=%0b rx=%0d ry=%0d ir=%0b want 1/3/6/0", i, t_if.out_valid, t_if.rx, t_if.ry, t_if.in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    t_if.in_valid = 1'b0;
    t_if.out_ready = 1'b1;
    @(posedge clk); #1;
    t_if.out_ready = 1'b0;
    n_checks++;
    if (t_if.out_valid !== 1'b0 || t_if.in_ready !== 1'b1) $display("FAIL hold_handshake: ov=%0b ir=%0b want 0/1", t_if.out_valid, t_if.in_ready);
    else n_pass++;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (t_if.out_valid !== 1'b0) $display("FAIL hold_no_ghost: ov=%0b want 0", t_if.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc = 0;
    int rx, ry;
    bit inf, ok;
    t_if.op = 1'b1; t_if.px = 8'd3; t_if.py = 8'd6; t_if.qx = 8'd0; t_if.qy = 8'd0;
    t_if.in_valid = 1'b1;
    @(posedge clk); #1;
    t_if.in_valid = 1'b0;
    while (u_toy.r_state != S_INV && cyc < 500) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (u_toy.r_state != S_INV) $display("FAIL mid_reach_inv: state=%0d want %0d", u_toy.r_state, S_INV);
    else n_pass++;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (t_if.out_valid !== 1'b0 || t_if.in_ready !== 1'b1 || t_if.rx !== 8'd0 || t_if.ry !== 8'd0)
      $display("FAIL mid_reset: ov=%0b ir=%0b rx=%0d ry=%0d want 0/1/0/0", t_if.out_valid, t_if.in_ready, t_if.rx, t_if.ry);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    n_checks++;
    if (t_if.out_valid !== 1'b0) $display("FAIL mid_no_emit: ov=%0b want 0", t_if.out_valid);
    else n_pass++;
    toy_txn(1'b0, 3, 6, 80, 10, 1, rx, ry, inf, cyc, ok);
    n_checks++;
    if (!ok || rx !== 80 || ry !== 87 || inf !== 1'b0) $display("FAIL mid_after: ok=%0b got (%0d,%0d,%0b) want (80,87,0)", ok, rx, ry, inf);
    else n_pass++;
  endtask

  task automatic test_random;
    int i, j, mode, hold, px, py, qx, qy, erx, ery, rx, ry, cyc;
    bit op, einf, inf, ok;
    for (int y = 0; y < TP; y++)
      for (int x = 0; x < TP; x++)
        if (md(y * y - (x * x * x + TA * x + 3)) == 0) begin pt_x.push_back(x); pt_y.push_back(y); end
    for (int k = 0; k < 40; k++) begin
      i = $urandom_range(0, pt_x.size() - 1);
      j = $urandom_range(0, pt_x.size() - 1);
      mode = $urandom_range(0, 5);
      op = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      px = pt_x[i]; py = pt_y[i]; qx = pt_x[j]; qy = pt_y[j];
      case (mode)
        0: begin px = 0; py = 0; end
        1: begin qx = 0; qy = 0; end
        2: begin qx = px; qy = md(TP - py); end
        3: begin qx = px; qy = py; end
        default: ;
      endcase
      ref_pt(int'(op), px, py, qx, qy, erx, ery, einf);
      toy_txn(op, px, py, qx, qy, hold, rx, ry, inf, cyc, ok);
      n_checks++;
      if (!ok || rx !== erx || ry !== ery || inf !== einf)
        $display("FAIL rand%0d op=%0b P=(%0d,%0d) Q=(%0d,%0d): ok=%0b got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                 k, op, px, py, qx, qy, ok, rx, ry, inf, erx, ery, einf);
      else n_pass++;
    end
  endtask

  task automatic test_secp;
    logic [255:0] gx = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    logic [255:0] gy = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    logic [255:0] ex = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    logic [255:0] ey = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    int cyc = 0;
    s_if.op = 1'b1; s_if.px = gx; s_if.py = gy; s_if.qx = '0; s_if.qy = '0;
    s_if.in_valid = 1'b1;
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    n_checks++;
    if (s_if.in_ready !== 1'b0) $display("FAIL secp_busy: in_ready=%0b want 0", s_if.in_ready);
    else n_pass++;
    while (!s_if.out_valid && cyc < 20000) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (s_if.out_valid !== 1'b1) $display("FAIL secp_timeout: out_valid=%0b want 1", s_if.out_valid);
    else n_pass++;
    n_checks++;
    if (s_if.rx !== ex || s_if.ry !== ey || s_if.r_inf !== 1'b0)
      $display("FAIL secp_2g: got x=%h y=%h inf=%0b want x=%h y=%h inf=0", s_if.rx, s_if.ry, s_if.r_inf, ex, ey);
    else n_pass++;
`ifdef ECPU_CYCLE_CNT_EN
    n_checks++;
    if (s_if.cycles !== 32'(cyc) || s_if.cycles == 32'd0) $display("FAIL secp_cycles: got %0d want %0d", s_if.cycles, cyc);
    else n_pass++;
`endif
    s_if.out_ready = 1'b1;
    @(posedge clk); #1;
    s_if.out_ready = 1'b0;
    s_if.op = 1'b0; s_if.px = gx; s_if.py = gy; s_if.qx = '0; s_if.qy = '0;
    s_if.in_valid = 1'b1;
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    cyc = 0;
    while (!s_if.out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (s_if.out_valid !== 1'b1 || s_if.rx !== gx || s_if.ry !== gy || s_if.r_inf !== 1'b0)
      $display("FAIL secp_p_plus_inf: ov=%0b x=%h inf=%0b want 1/G/0", s_if.out_valid, s_if.rx, s_if.r_inf);
    else n_pass++;
    s_if.out_ready = 1'b1;
    @(posedge clk); #1;
    s_if.out_ready = 1'b0;
  endtask

  initial begin
    t_if.in_valid = 1'b0; t_if.out_ready = 1'b0; t_if.op = 1'b0;
    t_if.px = '0; t_if.py = '0; t_if.qx = '0; t_if.qy = '0;
    s_if.in_valid = 1'b0; s_if.out_ready = 1'b0; s_if.op = 1'b0;
    s_if.px = '0; s_if.py = '0; s_if.qx = '0; s_if.qy = '0;
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_vectors;
    test_hold;
    test_reset_mid;
    test_random;
    test_secp;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
